// File: rtl/rv32_mod_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rv32_mod_bus_pkg
// Purpose : Shared FSM state encoding and legal byte-enable patterns.
// Revision: 1.0
// ============================================================================
package rv32_mod_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    function automatic logic be_legal(input logic [3:0] be);
        logic ok;
        case (be)
            BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3,
            BE_HALF0, BE_HALF1, BE_WORD: ok = 1'b1;
            default:                     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : rv32_mod_bus_pkg
`default_nettype wire

// File: rtl/rv32_mod_data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : rv32_mod_data_mem_responder_if
// Purpose : Request/response data bus between initiator and memory responder.
// Revision: 1.0
// ============================================================================
interface rv32_mod_data_mem_responder_if;

    logic        dext_req;
    logic        dext_wr;
    logic [3:0]  dext_be;
    logic [31:0] dext_addr;
    logic [31:0] dext_do;
    logic [31:0] dext_di;
    logic        dext_ack;
    logic        dext_err;

    modport master (
        output dext_req, dext_wr, dext_be, dext_addr, dext_do,
        input  dext_di, dext_ack, dext_err
    );

    modport slave (
        input  dext_req, dext_wr, dext_be, dext_addr, dext_do,
        output dext_di, dext_ack, dext_err
    );

endinterface : rv32_mod_data_mem_responder_if
`default_nettype wire

// File: rtl/rv32_mod_be_ram.sv
`default_nettype none
// ============================================================================
// Module  : rv32_mod_be_ram
// Purpose : Word RAM with per-lane write enables and a synchronous read port.
// Revision: 1.0
// ============================================================================
module rv32_mod_be_ram #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW         = $clog2(DEPTH_WORDS)
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [3:0]    be,
    input  wire logic [AW-1:0] waddr,
    input  wire logic [31:0]   wdata,
    input  wire logic          re,
    input  wire logic [AW-1:0] raddr,
    output logic      [31:0]   rdata
);

    // One byte-wide array per lane keeps each lane a single-writer memory.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem_q [DEPTH_WORDS];
        logic [7:0] rd_byte_q;

        always_ff @(posedge clk) begin
            if (we && be[i]) begin
                mem_q[waddr] <= wdata[8*i +: 8];
            end
            if (re) begin
                rd_byte_q <= mem_q[raddr];
            end
        end

        assign rdata[8*i +: 8] = rd_byte_q;
    end

endmodule : rv32_mod_be_ram
`default_nettype wire

// File: rtl/rv32_mod_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : rv32_mod_data_mem_responder
// Purpose : Data-memory slave with range/byte-enable checking and wait states.
// Revision: 1.0
// ============================================================================
module rv32_mod_data_mem_responder
    import rv32_mod_bus_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input wire logic                     clk,
    input wire logic                     reset_n,
    rv32_mod_data_mem_responder_if.slave bus
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
    localparam logic [31:0] ADDR_MASK = ~(SPAN - 32'd1);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES);
    localparam bit          HAS_WAIT  = (WAIT_STATES != 0);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [3:0]      be_q, be_d;
    logic [AW-1:0]   widx_q, widx_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            di_valid_q, di_valid_d;

    logic            legal;
    logic            commit;
    logic            acc_wr;
    logic [3:0]      acc_be;
    logic [AW-1:0]   acc_widx;
    logic [31:0]     acc_wdata;
    logic            ram_we;
    logic            ram_re;
    logic [31:0]     ram_rdata;

    assign legal = ((bus.dext_addr & ADDR_MASK) == BASE_ADDR) && be_legal(bus.dext_be);

    // With no wait states the access commits on the same edge that samples the
    // request, so the bus values are used directly instead of the latched copy.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_wr    = bus.dext_wr;
            acc_be    = bus.dext_be;
            acc_widx  = bus.dext_addr[AW+1:2];
            acc_wdata = bus.dext_do;
        end else begin
            acc_wr    = wr_q;
            acc_be    = be_q;
            acc_widx  = widx_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        be_d       = be_q;
        widx_d     = widx_q;
        wdata_d    = wdata_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        di_valid_d = di_valid_q;
        commit     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.dext_req) begin
                    wr_d    = bus.dext_wr;
                    be_d    = bus.dext_be;
                    widx_d  = bus.dext_addr[AW+1:2];
                    wdata_d = bus.dext_do;
                    if (!legal) begin
                        state_d    = ST_ERR;
                        err_d      = 1'b1;
                        di_valid_d = 1'b0;
                    end else if (HAS_WAIT) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        commit  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.dext_req) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ST_ACK;
                    cnt_d   = 4'd0;
                    ack_d   = 1'b1;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (commit && !acc_wr) begin
            di_valid_d = 1'b1;
        end
    end

    assign ram_we = commit && acc_wr;
    assign ram_re = commit && !acc_wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            be_q       <= 4'd0;
            widx_q     <= '0;
            wdata_q    <= 32'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            di_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            be_q       <= be_d;
            widx_q     <= widx_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            di_valid_q <= di_valid_d;
        end
    end

    rv32_mod_be_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (acc_be),
        .waddr (acc_widx),
        .wdata (acc_wdata),
        .re    (ram_re),
        .raddr (acc_widx),
        .rdata (ram_rdata)
    );

    // The RAM output register holds the last read word; the valid flag zeroes
    // it after reset or an error without needing a reset on the array.
    assign bus.dext_di  = di_valid_q ? ram_rdata : 32'd0;
    assign bus.dext_ack = ack_q;
    assign bus.dext_err = err_q;

endmodule : rv32_mod_data_mem_responder
`default_nettype wire

// File: tb/tb_rv32_mod_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv32_mod_data_mem_responder
// Purpose : Directed bench for the responder with 0 and 3 wait states.
// Revision: 1.0
// ============================================================================
module tb_rv32_mod_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sel = 1'b0;
    logic        req = 1'b0;
    logic        wr_s = 1'b0;
    logic [3:0]  be_s = 4'd0;
    logic [31:0] addr_s = 32'd0;
    logic [31:0] wd_s = 32'd0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rv32_mod_data_mem_responder_if bus0 ();
    rv32_mod_data_mem_responder_if bus1 ();

    assign bus0.dext_req  = req & ~sel;
    assign bus1.dext_req  = req & sel;
    assign bus0.dext_wr   = wr_s;
    assign bus1.dext_wr   = wr_s;
    assign bus0.dext_be   = be_s;
    assign bus1.dext_be   = be_s;
    assign bus0.dext_addr = addr_s;
    assign bus1.dext_addr = addr_s;
    assign bus0.dext_do   = wd_s;
    assign bus1.dext_do   = wd_s;

    wire        ack_o = sel ? bus1.dext_ack : bus0.dext_ack;
    wire        err_o = sel ? bus1.dext_err : bus0.dext_err;
    wire [31:0] di_o  = sel ? bus1.dext_di  : bus0.dext_di;

    rv32_mod_data_mem_responder #(
        .DEPTH_WORDS (1024), .BASE_ADDR (32'h0), .WAIT_STATES (0)
    ) dut0 (
        .clk (clk), .reset_n (reset_n), .bus (bus0.slave)
    );

    rv32_mod_data_mem_responder #(
        .DEPTH_WORDS (1024), .BASE_ADDR (32'h0), .WAIT_STATES (3)
    ) dut1 (
        .clk (clk), .reset_n (reset_n), .bus (bus1.slave)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        exp_err;
        logic        chk_di;
        logic [31:0] exp_di;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic txn(input string name, input logic wr, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic exp_err, input logic chk_di,
                       input logic [31:0] exp_di, input int exp_lat);
        int  n;
        bit  got;
        @(negedge clk);
        req = 1'b1; wr_s = wr; be_s = be; addr_s = addr; wd_s = wd;
        n = 0; got = 1'b0;
        while (!got && n < 20) begin
            cyc();
            n++;
            if (ack_o || err_o) got = 1'b1;
        end
        if (!got) begin
            chk({name, " timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, " ack/err"}, {30'd0, ack_o, err_o}, exp_err ? 32'd1 : 32'd2);
            chk({name, " latency"}, 32'(n), 32'(exp_lat));
            if (chk_di) chk({name, " data"}, di_o, exp_di);
        end
        req = 1'b0;
        cyc();
        chk({name, " pulse width"}, {30'd0, ack_o, err_o}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 4'b1111, 32'h10,   32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 4'b1111, 32'h10,   32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'b0100, 32'h10,   32'h00AA0000, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 4'b0001, 32'h10,   32'h0,        1'b0, 1'b1, 32'hDEAABEEF};
        vecs[4]  = '{1'b0, 4'b1111, 32'h1000, 32'h0,        1'b1, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 4'b1111, 32'h10,   32'h0,        1'b0, 1'b1, 32'hDEAABEEF};
        vecs[6]  = '{1'b1, 4'b0101, 32'h10,   32'hFFFFFFFF, 1'b1, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 4'b1100, 32'h12,   32'h0,        1'b0, 1'b1, 32'hDEAABEEF};
        vecs[8]  = '{1'b1, 4'b1111, 32'h14,   32'h0,        1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 4'b0011, 32'h14,   32'h00001234, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{1'b1, 4'b1100, 32'h14,   32'h56780000, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 4'b1111, 32'h1004, 32'h99999999, 1'b1, 1'b1, 32'h0};
        vecs[12] = '{1'b1, 4'b1000, 32'h14,   32'hAB00CDEF, 1'b0, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 4'b0010, 32'h14,   32'h0,        1'b0, 1'b1, 32'hAB781234};

        // Reset state of both responders
        #1;
        sel = 1'b0;
        chk("reset ack0", {31'd0, bus0.dext_ack}, 32'd0);
        chk("reset err0", {31'd0, bus0.dext_err}, 32'd0);
        chk("reset di0",  bus0.dext_di, 32'd0);
        chk("reset ack1", {31'd0, bus1.dext_ack}, 32'd0);
        chk("reset di1",  bus1.dext_di, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            txn($sformatf("ws0 vec%0d", i), vecs[i].wr, vecs[i].be, vecs[i].addr,
                vecs[i].wd, vecs[i].exp_err, vecs[i].chk_di, vecs[i].exp_di,
                1);
        end

        // Back-to-back write then read of the same word, no idle gap
        @(negedge clk);
        req = 1'b1; wr_s = 1'b1; be_s = 4'b1111; addr_s = 32'h40; wd_s = 32'hCAFEF00D;
        cyc();
        chk("b2b write ack", {31'd0, ack_o}, 32'd1);
        wr_s = 1'b0;
        cyc();
        chk("b2b gap", {30'd0, ack_o, err_o}, 32'd0);
        cyc();
        chk("b2b read ack", {31'd0, ack_o}, 32'd1);
        chk("b2b read data", di_o, 32'hCAFEF00D);
        req = 1'b0;
        cyc();

        // Three wait states
        sel = 1'b1;
        txn("ws3 wr20", 1'b1, 4'b1111, 32'h20, 32'hAAAA5555, 1'b0, 1'b0, 32'h0, 4);
        txn("ws3 rd20", 1'b0, 4'b1111, 32'h20, 32'h0,        1'b0, 1'b1, 32'hAAAA5555, 4);
        txn("ws3 badbe", 1'b0, 4'b0110, 32'h20, 32'h0,       1'b1, 1'b1, 32'h0, 1);

        // Request withdrawn in the second wait cycle
        @(negedge clk);
        req = 1'b1; wr_s = 1'b1; be_s = 4'b1111; addr_s = 32'h20; wd_s = 32'h11111111;
        cyc();
        cyc();
        req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk($sformatf("abort quiet%0d", k), {30'd0, ack_o, err_o}, 32'd0);
        end
        txn("abort rd20", 1'b0, 4'b1111, 32'h20, 32'h0, 1'b0, 1'b1, 32'hAAAA5555, 4);

        // Reset during the wait of a write
        @(negedge clk);
        req = 1'b1; wr_s = 1'b1; be_s = 4'b1111; addr_s = 32'h20; wd_s = 32'h0BADF00D;
        cyc();
        cyc();
        reset_n = 1'b0;
        req = 1'b0;
        #1;
        chk("rst di async", di_o, 32'd0);
        chk("rst ack async", {30'd0, ack_o, err_o}, 32'd0);
        cyc();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk($sformatf("rst quiet%0d", k), {30'd0, ack_o, err_o}, 32'd0);
        end
        txn("rst rd20", 1'b0, 4'b1111, 32'h20, 32'h0, 1'b0, 1'b1, 32'hAAAA5555, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rv32_mod_data_mem_responder
`default_nettype wire
